// File: rtl/jelly3_img_color_matrix_pkg.sv
// Shared types and constants for the 3x3 colour matrix: coefficient/offset types, identity, latency.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package jelly3_img_color_matrix_pkg;

    localparam int LATENCY           = 5;
    localparam int DEFAULT_DATA_BITS = 10;
    localparam int DEFAULT_COEF_BITS = 18;
    localparam int DEFAULT_COEF_FRAC = 12;

    typedef logic signed [DEFAULT_COEF_BITS-1:0] coef_t;
    typedef logic signed [DEFAULT_DATA_BITS:0]   offset_t;
    typedef coef_t [2:0][2:0]                    coef_matrix_t;

    localparam coef_matrix_t IDENTITY_MATRIX = '{
        '{coef_t'(1 << DEFAULT_COEF_FRAC), coef_t'(0), coef_t'(0)},
        '{coef_t'(0), coef_t'(1 << DEFAULT_COEF_FRAC), coef_t'(0)},
        '{coef_t'(0), coef_t'(0), coef_t'(1 << DEFAULT_COEF_FRAC)}
    };

    // Identity element for arbitrary coefficient formats (1.0 on the diagonal).
    function automatic longint identity_coef(input int row, input int col, input int frac);
        return (row == col) ? (longint'(1) << frac) : longint'(0);
    endfunction

endpackage

// File: rtl/jelly3_img_color_matrix_if.sv
// Pixel stream bundle: raster flags, user side-band and {raw,r,g,b} components.
// Latency: n/a (wiring only).
// Backpressure: none; valid only qualifies data.
interface jelly3_img_if #(
    parameter int DATA_BITS = 10,
    parameter int USER_BITS = 1
) (
    input var logic reset,
    input var logic clk
);
    logic                        row_first;
    logic                        row_last;
    logic                        col_first;
    logic                        col_last;
    logic                        de;
    logic [USER_BITS-1:0]        user;
    logic [3:0][DATA_BITS-1:0]   data;
    logic                        valid;

    modport s (
        input reset, clk,
        input row_first, row_last, col_first, col_last, de, user, data, valid
    );

    modport m (
        input  reset, clk,
        output row_first, row_last, col_first, col_last, de, user, data, valid
    );
endinterface

// File: rtl/jelly2_img_delay.sv
// Fixed shift-register delay for raster flags, user side-band and a data word.
// Latency: LATENCY cke-enabled cycles.
// Backpressure: none; cke=0 freezes every stage.
module jelly2_img_delay #(
    parameter int LATENCY   = 5,
    parameter int USER_BITS = 1,
    parameter int DATA_BITS = 10
) (
    input  var logic                 reset,
    input  var logic                 clk,
    input  var logic                 cke,

    input  var logic                 s_row_first,
    input  var logic                 s_row_last,
    input  var logic                 s_col_first,
    input  var logic                 s_col_last,
    input  var logic                 s_de,
    input  var logic [USER_BITS-1:0] s_user,
    input  var logic [DATA_BITS-1:0] s_data,
    input  var logic                 s_valid,

    output logic                     m_row_first,
    output logic                     m_row_last,
    output logic                     m_col_first,
    output logic                     m_col_last,
    output logic                     m_de,
    output logic [USER_BITS-1:0]     m_user,
    output logic [DATA_BITS-1:0]     m_data,
    output logic                     m_valid
);
    localparam int W = 6 + USER_BITS + DATA_BITS;

    logic [W-1:0] pipe [LATENCY];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else if (cke) begin
            pipe[0] <= {s_row_first, s_row_last, s_col_first, s_col_last, s_de, s_user, s_data, s_valid};
            for (int i = 1; i < LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign {m_row_first, m_row_last, m_col_first, m_col_last, m_de, m_user, m_data, m_valid} = pipe[LATENCY-1];

endmodule

// File: rtl/jelly3_img_color_matrix_calc.sv
// One output channel: 3 MACs, offset, optional round (JELLY3_IMG_COLOR_MATRIX_ROUND_EN), shift, clip.
// Latency: 4 cke cycles (products, pair sum, offset+shift, clip) after the caller's input register.
// Backpressure: none; cke=0 freezes every stage.
module jelly3_img_color_matrix_calc #(
    parameter int DATA_BITS   = 10,
    parameter int COEF_BITS   = 18,
    parameter int COEF_FRAC   = 12,
    parameter int OFFSET_BITS = DATA_BITS + 1
) (
    input  var logic                          reset,
    input  var logic                          clk,
    input  var logic                          cke,
    input  var logic [2:0][DATA_BITS-1:0]     in_data,
    input  var logic [2:0][COEF_BITS-1:0]     coef,
    input  var logic [OFFSET_BITS-1:0]        offset,
    output logic     [DATA_BITS-1:0]          out_data
);
    localparam int PROD_BITS   = DATA_BITS + COEF_BITS + 1;
    localparam int OFS_SH_BITS = OFFSET_BITS + COEF_FRAC;
    localparam int BASE_BITS   = (PROD_BITS > OFS_SH_BITS) ? PROD_BITS : OFS_SH_BITS;
    localparam int ACC_BITS    = BASE_BITS + 2;

`ifdef JELLY3_IMG_COLOR_MATRIX_ROUND_EN
    localparam logic signed [ACC_BITS-1:0] RND = ACC_BITS'(1) << (COEF_FRAC - 1);
`else
    localparam logic signed [ACC_BITS-1:0] RND = '0;
`endif
    localparam logic signed [ACC_BITS-1:0] MAX_VAL = {{(ACC_BITS-DATA_BITS){1'b0}}, {DATA_BITS{1'b1}}};

    logic signed [PROD_BITS-1:0]   ext_in   [3];
    logic signed [PROD_BITS-1:0]   ext_coef [3];

    logic signed [PROD_BITS-1:0]   st1_prod [3];
    logic signed [OFFSET_BITS-1:0] st1_ofs;
    logic signed [ACC_BITS-1:0]    st2_sum01;
    logic signed [PROD_BITS-1:0]   st2_prod2;
    logic signed [OFFSET_BITS-1:0] st2_ofs;
    logic signed [ACC_BITS-1:0]    st3_acc;
    logic signed [ACC_BITS-1:0]    st3_shift;

    // Inputs are unsigned pixels: zero-extend before the signed multiply.
    always_comb begin
        for (int j = 0; j < 3; j++) begin
            ext_in[j]   = PROD_BITS'($signed({1'b0, in_data[j]}));
            ext_coef[j] = PROD_BITS'($signed(coef[j]));
        end
    end

    always_comb begin
        st3_acc = st2_sum01 + ACC_BITS'(st2_prod2) + (ACC_BITS'(st2_ofs) <<< COEF_FRAC) + RND;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < 3; j++) begin
                st1_prod[j] <= '0;
            end
            st1_ofs   <= '0;
            st2_sum01 <= '0;
            st2_prod2 <= '0;
            st2_ofs   <= '0;
            st3_shift <= '0;
            out_data  <= '0;
        end else if (cke) begin
            for (int j = 0; j < 3; j++) begin
                st1_prod[j] <= ext_in[j] * ext_coef[j];
            end
            st1_ofs   <= $signed(offset);

            st2_sum01 <= ACC_BITS'(st1_prod[0]) + ACC_BITS'(st1_prod[1]);
            st2_prod2 <= st1_prod[2];
            st2_ofs   <= st1_ofs;

            st3_shift <= st3_acc >>> COEF_FRAC;

            if (st3_shift < 0) begin
                out_data <= '0;
            end else if (st3_shift > MAX_VAL) begin
                out_data <= {DATA_BITS{1'b1}};
            end else begin
                out_data <= st3_shift[DATA_BITS-1:0];
            end
        end
    end

endmodule

// File: rtl/jelly3_img_color_matrix_core.sv
// 3x3 colour matrix with per-channel offset; coefficients swap only at frame start. Rounding: JELLY3_IMG_COLOR_MATRIX_ROUND_EN.
// Latency: 5 cke cycles (in-reg, products, pair sums, offset+shift, clip); raw and flags aligned.
// Backpressure: none; valid only qualifies output, cke=0 freezes all state.
module jelly3_img_color_matrix_core
    import jelly3_img_color_matrix_pkg::*;
#(
    parameter int DATA_BITS   = 10,
    parameter int COEF_BITS   = 18,
    parameter int COEF_FRAC   = 12,
    parameter int OFFSET_BITS = DATA_BITS + 1,
    parameter int USER_BITS   = 1
) (
    input  var logic                              reset,
    input  var logic                              clk,
    input  var logic                              cke,

    input  var logic [2:0][2:0][COEF_BITS-1:0]    param_matrix,
    input  var logic [2:0][OFFSET_BITS-1:0]       param_offset,
    input  var logic                              param_update,
    output logic                                  param_busy,

    jelly3_img_if.s                               s_img,
    jelly3_img_if.m                               m_img
);
    logic [2:0][2:0][COEF_BITS-1:0] act_matrix;
    logic [2:0][OFFSET_BITS-1:0]    act_offset;
    logic                           pending;
    logic                           frame_start;
    logic [2:0][DATA_BITS-1:0]      st0_rgb;
    logic [DATA_BITS-1:0]           out_rgb [3];
    logic [DATA_BITS-1:0]           raw_d;

    assign frame_start = s_img.valid & s_img.row_first & s_img.col_first;
    assign param_busy  = pending;

    // Active registers change on the same edge that captures the frame-start
    // pixel, so that pixel is the first one multiplied with the new matrix.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    act_matrix[i][j] <= COEF_BITS'(identity_coef(i, j, COEF_FRAC));
                end
            end
            act_offset <= '0;
            pending    <= 1'b0;
        end else if (cke) begin
            if (frame_start && (pending || param_update)) begin
                act_matrix <= param_matrix;
                act_offset <= param_offset;
                pending    <= 1'b0;
            end else if (param_update) begin
                pending    <= 1'b1;
            end
        end
    end

    // Component index 0/1/2 = R/G/B; the bus packs {raw, r, g, b} from the top.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st0_rgb <= '0;
        end else if (cke) begin
            st0_rgb[0] <= s_img.data[2];
            st0_rgb[1] <= s_img.data[1];
            st0_rgb[2] <= s_img.data[0];
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_ch
        jelly3_img_color_matrix_calc #(
            .DATA_BITS   (DATA_BITS),
            .COEF_BITS   (COEF_BITS),
            .COEF_FRAC   (COEF_FRAC),
            .OFFSET_BITS (OFFSET_BITS)
        ) u_calc (
            .reset    (reset),
            .clk      (clk),
            .cke      (cke),
            .in_data  (st0_rgb),
            .coef     (act_matrix[i]),
            .offset   (act_offset[i]),
            .out_data (out_rgb[i])
        );
    end

    jelly2_img_delay #(
        .LATENCY   (LATENCY),
        .USER_BITS (USER_BITS),
        .DATA_BITS (DATA_BITS)
    ) u_delay (
        .reset       (reset),
        .clk         (clk),
        .cke         (cke),
        .s_row_first (s_img.row_first),
        .s_row_last  (s_img.row_last),
        .s_col_first (s_img.col_first),
        .s_col_last  (s_img.col_last),
        .s_de        (s_img.de),
        .s_user      (s_img.user),
        .s_data      (s_img.data[3]),
        .s_valid     (s_img.valid),
        .m_row_first (m_img.row_first),
        .m_row_last  (m_img.row_last),
        .m_col_first (m_img.col_first),
        .m_col_last  (m_img.col_last),
        .m_de        (m_img.de),
        .m_user      (m_img.user),
        .m_data      (raw_d),
        .m_valid     (m_img.valid)
    );

    assign m_img.data = {raw_d, out_rgb[0], out_rgb[1], out_rgb[2]};

endmodule
